// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller: face table, FSM states, LFSR constants.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        REDUCE,
        DONE
    } state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam logic [6:0] FACE_LUT [8] = '{7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'd30, 7'd100};

    function automatic logic is_onehot(input logic [7:0] sw);
        return (sw != '0) && ((sw & (sw - 8'd1)) == '0);
    endfunction

    function automatic logic [6:0] face_of(input logic [7:0] sw);
        logic [6:0] f;
        f = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (sw[b]) f = FACE_LUT[b];
        end
        return f;
    endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); a zero seed falls back to DEFAULT_SEED.
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] SEED_EFF = (SEED == '0) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) lfsr_q <= SEED_EFF;
        else          lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/dice_roller_multi.sv
// Multi-die roller: Roll press/release draws NUM_DICE values in 1..Face from an LFSR.
// Optional spin animation on Dice while Roll is held: define DICE_SPIN_DISPLAY_EN.
module dice_roller_multi
    import dice_pkg::*;
#(
    parameter int unsigned  NUM_DICE = 2,
    parameter int unsigned  VAL_W    = 7,
    parameter logic [15:0]  SEED     = DEFAULT_SEED,
    localparam int unsigned SUM_W    = VAL_W + $clog2(NUM_DICE + 1)
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [7:0]                SWIn,
    input  logic                      Roll,
    output logic [NUM_DICE*VAL_W-1:0] Dice,
    output logic [SUM_W-1:0]          Sum,
    output logic [VAL_W-1:0]          Face,
    output logic                      Valid,
    output logic                      Busy,
    output logic                      Err
);

    localparam int unsigned KW = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;

    state_e                    state_q, state_d;
    logic                      roll_prev_q;
    logic [VAL_W-1:0]          face_q, face_d;
    logic [VAL_W-1:0]          raw_q, raw_d;
    logic [NUM_DICE*VAL_W-1:0] dice_q, dice_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [KW-1:0]             k_q, k_d;
    logic                      load_q, load_d;
    logic                      err_q, err_d;
    logic [15:0]               lfsr_w;
    logic                      lfsr_unused;

    dice_lfsr #(.SEED(SEED)) u_lfsr (
        .clk_i   (Clk),
        .rst_n_i (Rst_n),
        .state_o (lfsr_w)
    );

    assign lfsr_unused = ^lfsr_w[15:7];

    always_comb begin
        state_d = state_q;
        face_d  = face_q;
        raw_d   = raw_q;
        dice_d  = dice_q;
        sum_d   = sum_q;
        k_d     = k_q;
        load_d  = load_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (Roll && !roll_prev_q) begin
                    if (is_onehot(SWIn)) begin
                        face_d  = VAL_W'(face_of(SWIn));
                        err_d   = 1'b0;
                        state_d = SPIN;
`ifdef DICE_SPIN_DISPLAY_EN
                        for (int unsigned i = 0; i < NUM_DICE; i++) begin
                            dice_d[i*VAL_W +: VAL_W] = VAL_W'((i % 32'(face_of(SWIn))) + 1);
                        end
                        sum_d = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SPIN: begin
                if (!Roll) begin
                    state_d = REDUCE;
                    k_d     = '0;
                    load_d  = 1'b1;
                    sum_d   = '0;
                end else begin
`ifdef DICE_SPIN_DISPLAY_EN
                    for (int unsigned i = 0; i < NUM_DICE; i++) begin
                        if (dice_q[i*VAL_W +: VAL_W] >= face_q) dice_d[i*VAL_W +: VAL_W] = VAL_W'(1);
                        else dice_d[i*VAL_W +: VAL_W] = dice_q[i*VAL_W +: VAL_W] + VAL_W'(1);
                    end
`endif
                end
            end
            REDUCE: begin
                // Modulo by repeated subtraction: one load cycle, then subtract until raw < Face.
                if (load_q) begin
                    raw_d  = VAL_W'(lfsr_w[6:0]);
                    load_d = 1'b0;
                end else if (raw_q >= face_q) begin
                    raw_d = raw_q - face_q;
                end else begin
                    dice_d[k_q*VAL_W +: VAL_W] = raw_q + VAL_W'(1);
                    sum_d = sum_q + SUM_W'(raw_q) + SUM_W'(1);
                    if (k_q == KW'(NUM_DICE - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d    = k_q + KW'(1);
                        load_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            roll_prev_q <= 1'b1;
            face_q      <= '0;
            raw_q       <= '0;
            dice_q      <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            roll_prev_q <= Roll;
            face_q      <= face_d;
            raw_q       <= raw_d;
            dice_q      <= dice_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            load_q      <= load_d;
            err_q       <= err_d;
        end
    end

    assign Dice  = dice_q;
    assign Sum   = sum_q;
    assign Face  = face_q;
    assign Err   = err_q;
    assign Valid = (state_q == DONE);
    assign Busy  = (state_q == SPIN) || (state_q == REDUCE);

endmodule

// File: tb/tb_dice_roller_multi.sv
// Self-checking bench for dice_roller_multi against a cycle-indexed LFSR history model.
module tb_dice_roller_multi;

    localparam int NUM_DICE = 2;
    localparam int VAL_W    = 7;
    localparam int SUM_W    = 9;
    localparam int HMAX     = 131071;

    logic                      Clk   = 1'b0;
    logic                      Rst_n = 1'b0;
    logic                      Roll  = 1'b1;
    logic [7:0]                SWIn  = 8'b00000010;
    logic [NUM_DICE*VAL_W-1:0] Dice;
    logic [SUM_W-1:0]          Sum;
    logic [VAL_W-1:0]          Face;
    logic                      Valid, Busy, Err;

    dice_roller_multi #(.NUM_DICE(NUM_DICE), .VAL_W(VAL_W), .SEED(16'hACE1)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .SWIn(SWIn), .Roll(Roll),
        .Dice(Dice), .Sum(Sum), .Face(Face), .Valid(Valid), .Busy(Busy), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // hist[n] = LFSR contents after n rising edges since reset release
    int          cyc;
    logic [15:0] hist [0:HMAX];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cyc     <= 0;
            hist[0] <= 16'hACE1;
        end else if (cyc < HMAX) begin
            hist[cyc+1] <= lfsr_next(hist[cyc]);
            cyc         <= cyc + 1;
        end
    end

    int exp_d [NUM_DICE];
    int exp_sum, exp_c;
    int m_last, v_last;
    bit got_last, busy_last;
    int prev_d [NUM_DICE];
    int prev_sum;

    function automatic int field(input int i);
        return int'(Dice[i*VAL_W +: VAL_W]);
    endfunction

    // Reference: REDUCE entered at edge m; each die loads at edge e using the LFSR value
    // before that edge, then needs raw/F subtract edges and one commit edge.
    task automatic model_roll(input int m, input int f);
        int e, raw;
        e       = m + 1;
        exp_sum = 0;
        exp_c   = 0;
        for (int k = 0; k < NUM_DICE; k++) begin
            raw      = int'(hist[e-1][6:0]);
            exp_d[k] = (raw % f) + 1;
            exp_sum += exp_d[k];
            exp_c    = e + raw / f + 1;
            e        = exp_c + 1;
        end
    endtask

    task automatic wait_valid();
        got_last = 1'b0;
        v_last   = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge Clk);
            if (Valid === 1'b1) begin
                got_last = 1'b1;
                v_last   = cyc;
                break;
            end
        end
    endtask

    task automatic do_roll(input int hold);
        @(negedge Clk);
        Roll = 1'b1;
        repeat (hold) @(negedge Clk);
        busy_last = Busy;
        Roll      = 1'b0;
        m_last    = cyc + 1;
        wait_valid();
    endtask

    task automatic save_prev();
        for (int i = 0; i < NUM_DICE; i++) prev_d[i] = field(i);
        prev_sum = int'(Sum);
    endtask

    task automatic test_reset();
        bit bad;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Dice, Sum, Face, Valid, Busy, Err} !== '0)
            $display("FAIL reset_values: got Dice=%h Sum=%0d Face=%0d V=%b B=%b E=%b expected all 0",
                     Dice, Sum, Face, Valid, Busy, Err);
        if ({Dice, Sum, Face, Valid, Busy, Err} !== '0) errors++;
        Rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Busy !== 1'b0 || Valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL held_roll_through_reset: got a roll started expected IDLE with Busy=0 Valid=0");
        end
        Roll = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_face6();
        SWIn = 8'b00000010;
        do_roll(5);
        model_roll(m_last, 6);
        checks++;
        if (got_last !== 1'b1) begin errors++; $display("FAIL f6_valid: got no pulse expected pulse"); end
        checks++;
        if (busy_last !== 1'b1) begin errors++; $display("FAIL f6_busy_spin: got %b expected 1", busy_last); end
        checks++;
        if (v_last !== exp_c) begin errors++; $display("FAIL f6_valid_cycle: got %0d expected %0d", v_last, exp_c); end
        checks++;
        if (v_last - m_last > 48 || v_last < 0) begin
            errors++; $display("FAIL f6_latency: got %0d expected <= 48", v_last - m_last);
        end
        for (int i = 0; i < NUM_DICE; i++) begin
            checks++;
            if (field(i) !== exp_d[i] || field(i) < 1 || field(i) > 6) begin
                errors++; $display("FAIL f6_die%0d: got %0d expected %0d", i, field(i), exp_d[i]);
            end
        end
        checks++;
        if (int'(Sum) !== exp_sum) begin errors++; $display("FAIL f6_sum: got %0d expected %0d", Sum, exp_sum); end
        checks++;
        if (Face !== 7'd6) begin errors++; $display("FAIL f6_face: got %0d expected 6", Face); end
        @(negedge Clk);
        checks++;
        if (Valid !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL f6_single_pulse: got V=%b B=%b expected 0 0", Valid, Busy);
        end
    endtask

    task automatic test_face100();
        int bad, maxsum;
        bit seen1, seen100;
        SWIn = 8'b10000000;
        bad = 0; maxsum = 0; seen1 = 0; seen100 = 0;
        for (int r = 0; r < 1000; r++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            do_roll(int'($urandom_range(1, 3)));
            model_roll(m_last, 100);
            checks++;
            if (got_last !== 1'b1 || v_last !== exp_c) begin
                errors++; $display("FAIL f100_valid r%0d: got cycle %0d expected %0d", r, v_last, exp_c);
            end
            for (int i = 0; i < NUM_DICE; i++) begin
                checks++;
                if (field(i) !== exp_d[i] || field(i) < 1 || field(i) > 100) begin
                    errors++; $display("FAIL f100_die%0d r%0d: got %0d expected %0d", i, r, field(i), exp_d[i]);
                end
                if (field(i) == 1) seen1 = 1'b1;
                if (field(i) == 100) seen100 = 1'b1;
            end
            checks++;
            if (int'(Sum) !== exp_sum) begin
                errors++; $display("FAIL f100_sum r%0d: got %0d expected %0d", r, Sum, exp_sum);
            end
            if (int'(Sum) > maxsum) maxsum = int'(Sum);
        end
        checks++;
        if (maxsum > 200) begin errors++; $display("FAIL f100_maxsum: got %0d expected <= 200", maxsum); end
        checks++;
        if (!seen1) begin errors++; $display("FAIL f100_seen1: got none expected at least one"); end
        checks++;
        if (!seen100) begin errors++; $display("FAIL f100_seen100: got none expected at least one"); end
    endtask

    task automatic test_err();
        bit bad;
        save_prev();
        SWIn = 8'b00000011;
        @(negedge Clk);
        Roll = 1'b1;
        @(negedge Clk);
        checks++;
        if (Err !== 1'b1 || Busy !== 1'b0) begin
            errors++; $display("FAIL err_set: got E=%b B=%b expected 1 0", Err, Busy);
        end
        Roll = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (Valid !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL err_idle: got activity expected idle"); end
        checks++;
        if (field(0) !== prev_d[0] || field(1) !== prev_d[1] || int'(Sum) !== prev_sum || Face !== 7'd100) begin
            errors++;
            $display("FAIL err_hold: got %0d %0d sum %0d face %0d expected %0d %0d sum %0d face 100",
                     field(0), field(1), Sum, Face, prev_d[0], prev_d[1], prev_sum);
        end
        SWIn = 8'b00000001;
        do_roll(2);
        model_roll(m_last, 4);
        checks++;
        if (Err !== 1'b0 || Face !== 7'd4) begin
            errors++; $display("FAIL err_clear: got E=%b Face=%0d expected 0 4", Err, Face);
        end
        checks++;
        if (got_last !== 1'b1 || v_last !== exp_c || field(0) !== exp_d[0] || field(1) !== exp_d[1]
            || int'(Sum) !== exp_sum) begin
            errors++;
            $display("FAIL err_next_roll: got cyc %0d %0d %0d sum %0d expected cyc %0d %0d %0d sum %0d",
                     v_last, field(0), field(1), Sum, exp_c, exp_d[0], exp_d[1], exp_sum);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        SWIn = 8'b00000001;
        @(negedge Clk);
        Roll = 1'b1;
        @(negedge Clk);
        Roll = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1) begin errors++; $display("FAIL mid_in_reduce: got B=%b expected 1", Busy); end
        #1 Rst_n = 1'b0;
        #1;
        checks++;
        if ({Dice, Sum, Face, Valid, Busy, Err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: got Dice=%h Sum=%0d Face=%0d V=%b B=%b E=%b expected all 0",
                     Dice, Sum, Face, Valid, Busy, Err);
        end
        bad = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if ({Dice, Sum, Face, Valid, Busy, Err} !== '0) bad = 1'b1;
        end
        Rst_n = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            if (Valid !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL mid_no_valid: got activity expected quiet reset state"); end
        do_roll(1);
        model_roll(m_last, 4);
        checks++;
        if (busy_last !== 1'b1 || got_last !== 1'b1 || v_last !== exp_c) begin
            errors++; $display("FAIL mid_after_roll_timing: got cyc %0d busy %b expected cyc %0d busy 1",
                               v_last, busy_last, exp_c);
        end
        checks++;
        if (field(0) !== exp_d[0] || field(1) !== exp_d[1] || int'(Sum) !== exp_sum || Face !== 7'd4) begin
            errors++; $display("FAIL mid_after_roll_values: got %0d %0d sum %0d expected %0d %0d sum %0d",
                               field(0), field(1), Sum, exp_d[0], exp_d[1], exp_sum);
        end
    endtask

    task automatic test_spin();
        int bad, ed, es;
        save_prev();
        SWIn = 8'b00000001;
        bad = 0;
        @(negedge Clk);
        Roll = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge Clk);
            for (int i = 0; i < NUM_DICE; i++) begin
`ifdef DICE_SPIN_DISPLAY_EN
                ed = ((i % 4) + j) % 4 + 1;
                es = 0;
`else
                ed = prev_d[i];
                es = prev_sum;
`endif
                if (field(i) !== ed || int'(Sum) !== es) begin
                    bad++;
                    $display("FAIL spin_display j%0d die%0d: got %0d sum %0d expected %0d sum %0d",
                             j, i, field(i), Sum, ed, es);
                end
            end
        end
        checks++;
        if (bad != 0) errors++;
        Roll   = 1'b0;
        m_last = cyc + 1;
        wait_valid();
        model_roll(m_last, 4);
        checks++;
        if (got_last !== 1'b1 || v_last !== exp_c || field(0) !== exp_d[0] || field(1) !== exp_d[1]
            || int'(Sum) !== exp_sum) begin
            errors++;
            $display("FAIL spin_then_reduce: got cyc %0d %0d %0d sum %0d expected cyc %0d %0d %0d sum %0d",
                     v_last, field(0), field(1), Sum, exp_c, exp_d[0], exp_d[1], exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_face6();
        test_face100();
        test_err();
        test_reset_mid();
        test_spin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
